oled_screen_driver: RTL and testbench

OLED_SCREEN_DRIVER -- requirements
Module: oled_screen_driver

---
 rtl/oled_pkg.sv | 32 +++
 rtl/oled_spi_shifter.sv | 62 ++++++
 rtl/oled_screen_driver.sv | 149 ++++++++++++++
 tb/tb_oled_screen_driver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 OLED screen driver:
// the init command table, frame geometry and the driver FSM state set.
package oled_pkg;

    localparam int N_INIT_CMDS = 16;
    localparam int FRAME_BYTES = 1024;
    localparam int ADDR_W      = 10;

    // Display off, horizontal addressing, contrast, segment/COM remap,
    // 64-row mux, zero offset, charge pump on, resume RAM, normal, on.
    localparam logic [7:0] INIT_CMDS [N_INIT_CMDS] = '{
        8'hAE, 8'h20, 8'h00, 8'h81,
        8'h7F, 8'hA1, 8'hC8, 8'hA8,
        8'h3F, 8'hD3, 8'h00, 8'h8D,
        8'h14, 8'hA4, 8'hA6, 8'hAF
    };

    typedef enum logic [2:0] {
        PWR_WAIT,
        RST_PULSE,
        RST_WAIT,
        LOAD_CMD,
        LOAD_DATA,
        FETCH,
        SEND
    } oled_state_e;

    function automatic logic [7:0] init_cmd(input logic [3:0] idx);
        return INIT_CMDS[idx];
    endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// SPI byte serialiser: MSB first, two clocks per bit (sclk low, then high).
// Ports: clk_i/rst_i, load_i + data_i start a byte, sclk_o/sdin_o drive
// the panel, done_o marks the final sclk-high clock of the byte.
module oled_spi_shifter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       sclk_o,
    output logic       sdin_o,
    output logic       done_o
);

    logic [7:0] sreg_q, sreg_d;
    logic [2:0] bit_q, bit_d;
    logic       phase_q, phase_d;
    logic       busy_q, busy_d;

    always_comb begin
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        busy_d  = busy_q;
        if (load_i) begin
            sreg_d  = data_i;
            bit_d   = 3'd0;
            phase_d = 1'b0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                sreg_d  = {sreg_q[6:0], 1'b0};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    busy_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sreg_q  <= 8'h00;
            bit_q   <= 3'd0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
        end
    end

    // Idle bus parks with sclk high and sdin low.
    assign sclk_o = busy_q ? phase_q : 1'b1;
    assign sdin_o = busy_q & sreg_q[7];
    assign done_o = busy_q & phase_q & (bit_q == 3'd7);

endmodule

// File: rtl/oled_screen_driver.sv
// SSD1306 128x64 OLED driver: power/reset sequencing, 16-byte init, then
// endless streaming of the 1024-byte frame fetched via pixel_address_o.
// Ports: clk_i/rst_i (sync, active-high), pixel_address_o/pixel_data_i
// frame source, io_* panel pins, frame_done_o one-cycle wrap pulse.
module oled_screen_driver
    import oled_pkg::*;
#(
    parameter logic [31:0] STARTUP_WAIT = 32'd10_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [ADDR_W-1:0] pixel_address_o,
    input  logic [7:0]        pixel_data_i,
    output logic              io_sclk_o,
    output logic              io_sdin_o,
    output logic              io_cs_o,
    output logic              io_dc_o,
    output logic              io_reset_o,
    output logic              frame_done_o
);

    oled_state_e       state_q, state_d;
    logic [31:0]       wait_q, wait_d;
    logic [4:0]        cmd_idx_q, cmd_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              dc_q, dc_d;
    logic              frame_done_q, frame_done_d;

    logic              sh_load;
    logic [7:0]        sh_byte;
    logic              sh_done;
    logic              wait_last;

    // 33-bit compare so STARTUP_WAIT of 0 or 1 still ends after one clock.
    assign wait_last = ({1'b0, wait_q} + 33'd1) >= {1'b0, STARTUP_WAIT};

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        cmd_idx_d    = cmd_idx_q;
        addr_d       = addr_q;
        cs_d         = cs_q;
        dc_d         = dc_q;
        frame_done_d = 1'b0;
        sh_load      = 1'b0;
        sh_byte      = 8'h00;

        unique case (state_q)
            PWR_WAIT: begin
                wait_d = wait_q + 32'd1;
                if (wait_last) begin
                    wait_d  = 32'd0;
                    state_d = RST_PULSE;
                end
            end
            RST_PULSE: begin
                wait_d = wait_q + 32'd1;
                if (wait_last) begin
                    wait_d  = 32'd0;
                    state_d = RST_WAIT;
                end
            end
            RST_WAIT: begin
                wait_d = wait_q + 32'd1;
                if (wait_last) begin
                    wait_d    = 32'd0;
                    state_d   = LOAD_CMD;
                    cmd_idx_d = 5'd0;
                    cs_d      = 1'b0;
                    dc_d      = 1'b0;
                end
            end
            LOAD_CMD: begin
                sh_load   = 1'b1;
                sh_byte   = init_cmd(cmd_idx_q[3:0]);
                cmd_idx_d = cmd_idx_q + 5'd1;
                state_d   = SEND;
            end
            LOAD_DATA: begin
                state_d = FETCH;
            end
            FETCH: begin
                sh_load = 1'b1;
                sh_byte = pixel_data_i;
                state_d = SEND;
            end
            SEND: begin
                if (sh_done) begin
                    if (dc_q) begin
                        state_d = LOAD_DATA;
                        if (addr_q == ADDR_W'(FRAME_BYTES - 1)) begin
                            addr_d       = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end else if (cmd_idx_q == 5'(N_INIT_CMDS)) begin
                        state_d = LOAD_DATA;
                        dc_d    = 1'b1;
                        addr_d  = '0;
                    end else begin
                        state_d = LOAD_CMD;
                    end
                end
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= PWR_WAIT;
            wait_q       <= 32'd0;
            cmd_idx_q    <= 5'd0;
            addr_q       <= '0;
            cs_q         <= 1'b1;
            dc_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            cmd_idx_q    <= cmd_idx_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            dc_q         <= dc_d;
            frame_done_q <= frame_done_d;
        end
    end

    oled_spi_shifter u_shifter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (sh_load),
        .data_i (sh_byte),
        .sclk_o (io_sclk_o),
        .sdin_o (io_sdin_o),
        .done_o (sh_done)
    );

    assign pixel_address_o = addr_q;
    assign io_cs_o         = cs_q;
    assign io_dc_o         = dc_q;
    assign io_reset_o      = (state_q != RST_PULSE);
    assign frame_done_o    = frame_done_q;

endmodule

// File: tb/tb_oled_screen_driver.sv
// Directed bench for oled_screen_driver with STARTUP_WAIT=10: reset values,
// power sequencing, init bytes, data timing, frame wrap, mid-byte reset.
module tb_oled_screen_driver;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [9:0] pixel_address_o;
    logic [7:0] pixel_data_i = 8'h00;
    logic       io_sclk_o;
    logic       io_sdin_o;
    logic       io_cs_o;
    logic       io_dc_o;
    logic       io_reset_o;
    logic       frame_done_o;
    logic       force_a5 = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] b;
        logic       dc;
        int         t;
    } rec_t;

    rec_t       mq[$];
    int         cyc = 0;
    int         nbits = 0;
    int         t0 = 0;
    int         unstable = 0;
    logic [7:0] shreg = 8'h00;
    logic       prev_sclk = 1'b1;
    logic       prev_sdin = 1'b0;

    localparam logic [7:0] INIT [16] = '{
        8'hAE, 8'h20, 8'h00, 8'h81, 8'h7F, 8'hA1, 8'hC8, 8'hA8,
        8'h3F, 8'hD3, 8'h00, 8'h8D, 8'h14, 8'hA4, 8'hA6, 8'hAF
    };

    oled_screen_driver #(.STARTUP_WAIT(32'd10)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .pixel_address_o (pixel_address_o),
        .pixel_data_i    (pixel_data_i),
        .io_sclk_o       (io_sclk_o),
        .io_sdin_o       (io_sdin_o),
        .io_cs_o         (io_cs_o),
        .io_dc_o         (io_dc_o),
        .io_reset_o      (io_reset_o),
        .frame_done_o    (frame_done_o)
    );

    always #5 clk = ~clk;

    // Frame source: returns the low address byte one clock after the address.
    always @(posedge clk) begin
        pixel_data_i <= force_a5 ? 8'hA5 : pixel_address_o[7:0];
    end

    // SPI decoder: a bit is taken on each low->high sclk transition.
    always @(negedge clk) begin
        rec_t r;
        cyc++;
        if (io_cs_o) begin
            nbits = 0;
        end else if (io_sclk_o && !prev_sclk) begin
            if (io_sdin_o !== prev_sdin) unstable++;
            if (nbits == 0) t0 = cyc;
            shreg = {shreg[6:0], io_sdin_o};
            nbits++;
            if (nbits == 8) begin
                r.b  = shreg;
                r.dc = io_dc_o;
                r.t  = t0;
                mq.push_back(r);
                nbits = 0;
            end
        end
        prev_sclk = io_sclk_o;
        prev_sdin = io_sdin_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sclk"}, io_sclk_o, 1);
        chk({tag, "_sdin"}, io_sdin_o, 0);
        chk({tag, "_cs"}, io_cs_o, 1);
        chk({tag, "_dc"}, io_dc_o, 0);
        chk({tag, "_reset"}, io_reset_o, 1);
        chk({tag, "_addr"}, pixel_address_o, 0);
        chk({tag, "_fdone"}, frame_done_o, 0);
    endtask

    // Called on the negedge where rst_i has just been dropped.
    task automatic startup_seq();
        for (int i = 0; i < 30; i++) begin
            chk("io_reset_seq", io_reset_o, (i >= 10 && i < 20) ? 0 : 1);
            chk("cs_high_startup", io_cs_o, 1);
            @(negedge clk);
        end
        chk("cs_low", io_cs_o, 0);
        chk("dc_cmd", io_dc_o, 0);
    endtask

    task automatic wait_bytes(input int n);
        int k = 0;
        while (mq.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("byte_timeout", (mq.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic check_seq(input int n_data);
        for (int i = 0; i < 16; i++) begin
            chk("init_byte", {mq[i].dc, mq[i].b}, {1'b0, INIT[i]});
            if (i > 0) chk("cmd_period", mq[i].t - mq[i-1].t, 17);
        end
        for (int i = 16; i < 16 + n_data; i++) begin
            chk("data_byte", {mq[i].dc, mq[i].b}, {1'b1, 8'(i - 16)});
            chk("data_period", mq[i].t - mq[i-1].t, 18);
        end
    endtask

    initial begin
        int         k;
        int         n;
        logic [7:0] bb;
        logic [7:0] pat;

        repeat (3) begin
            @(negedge clk);
            check_reset_vals("hold");
        end
        rst_i = 1'b0;
        startup_seq();
        wait_bytes(19);
        check_seq(3);

        k = 0;
        while (!frame_done_o && k < 25000) begin
            @(negedge clk);
            k++;
        end
        chk("frame_done_seen", frame_done_o, 1);
        chk("addr_wrap", pixel_address_o, 0);
        chk("last_byte", {mq[$].dc, mq[$].b}, 9'h1FF);
        n = mq.size();
        chk("frame_bytes", n, 16 + 1024);
        @(negedge clk);
        chk("frame_done_pulse", frame_done_o, 0);
        wait_bytes(n + 1);
        chk("wrap_byte", {mq[n].dc, mq[n].b}, 9'h100);

        k = 0;
        while (pixel_address_o != 10'h155 && k < 8000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_155", pixel_address_o, 10'h155);
        repeat (4) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check_reset_vals("mid");
        rst_i = 1'b0;
        mq.delete();
        startup_seq();
        wait_bytes(17);
        check_seq(1);

        force_a5 = 1'b1;
        n = mq.size();
        wait_bytes(n + 2);
        bb = mq[n+1].b;
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk("a5_bit", bb[7-i], pat[7-i]);
        end
        chk("sdin_stable", unstable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
